coeff_seq: RTL and testbench
============================

Name: coeff_seq

Overview:
- Parametrised coefficient sequencer for the filter datapath.
- Holds a bank of NUM_COEFF coefficients, each COEFF_W bits wide, and streams them in index order over a valid/ready handshake.
- On start it takes a snapshot of the live coefficient bus, so a sweep stays coherent while the bus changes upstream.
- While idle it also supports registered random-access reads from the live bus.

Parameters:
- COEFF_W, 32, width of one coefficient.
- NUM_COEFF, 11, number of coefficients in the bank; legal range is 1 or more.
- IDX_W, 4, width of the index and address fields; must satisfy 2^IDX_W >= NUM_COEFF.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- GlobalReset  in  1  synchronous, active-high reset.
- coeff_bus  in  NUM_COEFF*COEFF_W  live coefficients; coefficient k occupies bits [k*COEFF_W +: COEFF_W].
- start  in  1  request a sweep.
- abort  in  1  cancel the sweep in progress.
- coeff_ready  in  1  downstream can accept the current coefficient.
- coeff_valid  out  1  coeff_out and coeff_idx are valid.
- coeff_out  out  COEFF_W  current sweep coefficient.
- coeff_idx  out  IDX_W  index of coeff_out.
- coeff_last  out  1  coeff_idx equals NUM_COEFF-1 while coeff_valid is high.
- busy  out  1  the state machine is in RUN.
- rd_en  in  1  random-access read request.
- rd_addr  in  IDX_W  random-access read address.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  COEFF_W  random-access read result.
- rd_err  out  1  the address of the read now being returned was out of range.

Behaviour:
- Reset: with GlobalReset=1 at a clock edge, the state goes to IDLE and every output clears to 0: coeff_valid, coeff_out, coeff_idx, coeff_last, busy, rd_valid, rd_data, rd_err. The snapshot bank also clears to 0. Reset overrides all other inputs. Reset during RUN ends the sweep and emits no further coefficients.
- All outputs are registered; no combinational path runs from any input to any output.
- Transfer: a coefficient transfers on an edge where coeff_valid and coeff_ready are both 1.
- IDLE, start=1:
  - Snapshot coeff_bus into the bank.
  - Next cycle: state RUN, busy=1, coeff_valid=1, coeff_idx=0, coeff_out equals coefficient 0 of the bus as it was on the start cycle.
  - Latency from start to first valid is 1 cycle.
- RUN, no transfer: coeff_out, coeff_idx, coeff_valid and coeff_last hold, regardless of snapshot or bus changes.
- RUN, transfer with idx < NUM_COEFF-1: idx increments and coeff_out takes the bank entry at the new index. Back-to-back transfers with coeff_ready held high give one coefficient per cycle.
- RUN, transfer with idx = NUM_COEFF-1:
  - If start=1 on that edge: re-snapshot the bus, set idx to 0, keep coeff_valid=1, stay in RUN. No bubble cycle.
  - Otherwise: go to IDLE with coeff_valid=0 and busy=0. coeff_out and coeff_idx hold their last values.
- start in RUN on any edge other than the final transfer is ignored.
- abort=1 in RUN: go to IDLE next cycle with coeff_valid=0, coeff_last=0, busy=0. abort takes priority over a simultaneous transfer. abort in IDLE has no effect.
- coeff_last equals coeff_valid AND (coeff_idx == NUM_COEFF-1). With NUM_COEFF=1 the first output is also the last.
- Random-access reads:
  - rd_en=1 in IDLE: on the next cycle rd_valid=1 for exactly one cycle.
  - rd_data is the live coeff_bus entry at rd_addr as sampled on the request edge; the snapshot bank is not used.
  - If rd_addr >= NUM_COEFF: rd_data returns coefficient 0 and rd_err=1; otherwise rd_err=0.
  - rd_data and rd_err hold until the next read.
  - Back-to-back rd_en gives one result per cycle.
- Priority and conflicts in IDLE:
  - start and rd_en together in IDLE: start wins and the read is dropped (rd_valid stays 0).
  - rd_en in RUN is dropped.

Test Plan:
1. Reset, then start with coeff_bus entries k*0x11111111+1 and coeff_ready held at 1 → coeff_valid high for 11 consecutive cycles; coeff_idx runs 0..10 with matching values; coeff_last only at idx 10; busy falls on the cycle after the final transfer.
2. Backpressure: during a sweep, drive coeff_ready as 1,0,0,1 at idx 3, and change coeff_bus during the stall → coeff_out holds the snapshotted value for coefficient 3 for 3 cycles, then advances to idx 4.
3. Drive start on the idx-10 transfer edge → the next cycle shows idx 0, coeff_valid 1, busy 1, with no idle cycle. Assert abort at idx 5 together with coeff_ready=1 → next cycle coeff_valid=0, busy=0, and coeff_idx stays 5.
4. In IDLE, read rd_addr=7, then 10, then 12 on consecutive cycles → three rd_valid pulses returning coefficients 7, 10 and 0; rd_err is 0, 0, 1.
5. Assert GlobalReset at idx 6 of a sweep → next cycle all outputs are 0 and the state is IDLE. Drive start and rd_en together in IDLE → a sweep begins and rd_valid stays 0.
6. Build with NUM_COEFF=1, COEFF_W=16 and start a sweep → a single output with coeff_last=1. The sweep terminates on the first transfer.

Source files
------------

// File: rtl/coeff_seq.sv
// coeff_seq: coefficient sequencer for the filter datapath.
// Snapshots the live coefficient bus on start and streams the bank in index
// order over a valid/ready handshake. While idle it serves registered
// random-access reads directly from the live bus.
module coeff_seq #(
    parameter int COEFF_W   = 32,
    parameter int NUM_COEFF = 11,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          GlobalReset,
    input  logic [NUM_COEFF*COEFF_W-1:0]  coeff_bus,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          coeff_ready,
    output logic                          coeff_valid,
    output logic [COEFF_W-1:0]            coeff_out,
    output logic [IDX_W-1:0]              coeff_idx,
    output logic                          coeff_last,
    output logic                          busy,
    input  logic                          rd_en,
    input  logic [IDX_W-1:0]              rd_addr,
    output logic                          rd_valid,
    output logic [COEFF_W-1:0]            rd_data,
    output logic                          rd_err
);

    localparam int                BANK_W   = NUM_COEFF * COEFF_W;
    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COEFF - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);

    // Select one coefficient from a packed bank; out-of-range picks entry 0.
    function automatic logic [COEFF_W-1:0] sel_coeff(
        input logic [BANK_W-1:0] bank,
        input logic [IDX_W-1:0]  idx
    );
        logic [COEFF_W-1:0] res;
        res = bank[0 +: COEFF_W];
        for (int k = 0; k < NUM_COEFF; k++) begin
            if (idx == IDX_W'(k)) begin
                res = bank[k*COEFF_W +: COEFF_W];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // True when the address names an existing coefficient.
    function automatic logic addr_in_range(input logic [IDX_W-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_COEFF; k++) begin
            if (addr == IDX_W'(k)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    logic [0:0]          state_r;
    logic [BANK_W-1:0]   bank_r;

    logic [0:0]          state_s;
    logic [BANK_W-1:0]   bank_s;
    logic                valid_s;
    logic [COEFF_W-1:0]  out_s;
    logic [IDX_W-1:0]    idx_s;
    logic                last_s;
    logic                rd_valid_s;
    logic [COEFF_W-1:0]  rd_data_s;
    logic                rd_err_s;
    logic                xfer_s;
    logic [IDX_W-1:0]    idx_inc_s;

    assign xfer_s    = coeff_valid & coeff_ready;
    assign idx_inc_s = coeff_idx + IDX_ONE;

    // Next-state and next-output computation for the sweep and read paths.
    always_comb begin
        state_s    = state_r;
        bank_s     = bank_r;
        valid_s    = coeff_valid;
        out_s      = coeff_out;
        idx_s      = coeff_idx;
        last_s     = coeff_last;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data;
        rd_err_s   = rd_err;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    // Start beats a concurrent read; the read is dropped.
                    state_s = ST_RUN;
                    bank_s  = coeff_bus;
                    valid_s = 1'b1;
                    out_s   = coeff_bus[0 +: COEFF_W];
                    idx_s   = IDX_ZERO;
                    last_s  = (IDX_ZERO == LAST_IDX);
                end else if (rd_en) begin
                    rd_valid_s = 1'b1;
                    rd_data_s  = sel_coeff(coeff_bus, rd_addr);
                    rd_err_s   = ~addr_in_range(rd_addr);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Index and data hold so the abort point stays visible.
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end else if (xfer_s) begin
                    if (coeff_idx == LAST_IDX) begin
                        if (start) begin
                            // Chained sweep: fresh snapshot, no bubble.
                            bank_s  = coeff_bus;
                            out_s   = coeff_bus[0 +: COEFF_W];
                            idx_s   = IDX_ZERO;
                            valid_s = 1'b1;
                            last_s  = (IDX_ZERO == LAST_IDX);
                        end else begin
                            state_s = ST_IDLE;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                        end
                    end else begin
                        idx_s  = idx_inc_s;
                        out_s  = sel_coeff(bank_r, idx_inc_s);
                        last_s = (idx_inc_s == LAST_IDX);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // State, bank and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_r     <= ST_IDLE;
            bank_r      <= '0;
            coeff_valid <= 1'b0;
            coeff_out   <= '0;
            coeff_idx   <= '0;
            coeff_last  <= 1'b0;
            busy        <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_err      <= 1'b0;
        end else begin
            state_r     <= state_s;
            bank_r      <= bank_s;
            coeff_valid <= valid_s;
            coeff_out   <= out_s;
            coeff_idx   <= idx_s;
            coeff_last  <= last_s;
            busy        <= (state_s == ST_RUN);
            rd_valid    <= rd_valid_s;
            rd_data     <= rd_data_s;
            rd_err      <= rd_err_s;
        end
    end

endmodule

// File: tb/tb_coeff_seq.sv
// Directed/randomized bench for coeff_seq: expectations come from arrays
// holding the live bus and the snapshot taken on each start.
module tb_coeff_seq;

    localparam int W  = 32;
    localparam int N  = 11;
    localparam int IW = 4;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N*W-1:0]  coeff_bus;
    logic            start, abort, coeff_ready, rd_en;
    logic [IW-1:0]   rd_addr;
    logic            coeff_valid, coeff_last, busy, rd_valid, rd_err;
    logic [W-1:0]    coeff_out, rd_data;
    logic [IW-1:0]   coeff_idx;

    logic [SW-1:0]   s_bus;
    logic            s_start, s_abort, s_ready, s_rd_en;
    logic [0:0]      s_rd_addr;
    logic            s_valid, s_last, s_busy, s_rd_valid, s_rd_err;
    logic [SW-1:0]   s_out, s_rd_data;
    logic [0:0]      s_idx;

    coeff_seq #(.COEFF_W(W), .NUM_COEFF(N), .IDX_W(IW)) dut (
        .clk(clk), .GlobalReset(rst), .coeff_bus(coeff_bus), .start(start),
        .abort(abort), .coeff_ready(coeff_ready), .coeff_valid(coeff_valid),
        .coeff_out(coeff_out), .coeff_idx(coeff_idx), .coeff_last(coeff_last),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err)
    );

    coeff_seq #(.COEFF_W(SW), .NUM_COEFF(1), .IDX_W(1)) dut_small (
        .clk(clk), .GlobalReset(rst), .coeff_bus(s_bus), .start(s_start),
        .abort(s_abort), .coeff_ready(s_ready), .coeff_valid(s_valid),
        .coeff_out(s_out), .coeff_idx(s_idx), .coeff_last(s_last),
        .busy(s_busy), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_valid(s_rd_valid),
        .rd_data(s_rd_data), .rd_err(s_rd_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] cur  [N];
    logic [W-1:0] snap [N];

    task automatic drive_bus();
        for (int k = 0; k < N; k++) coeff_bus[k*W +: W] = cur[k];
    endtask

    task automatic rand_bus();
        for (int k = 0; k < N; k++) cur[k] = $urandom;
        drive_bus();
    endtask

    task automatic take_snap();
        for (int k = 0; k < N; k++) snap[k] = cur[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_sweep(input string tag, input int i, input logic [W-1:0] v);
        chk({tag, "_valid"}, 64'(coeff_valid), 64'(1));
        chk({tag, "_idx"},   64'(coeff_idx),   64'(i));
        chk({tag, "_out"},   64'(coeff_out),   64'(v));
        chk({tag, "_last"},  64'(coeff_last),  64'(i == N - 1));
        chk({tag, "_busy"},  64'(busy),        64'(1));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},  64'(coeff_valid), 64'(0));
        chk({tag, "_out"},    64'(coeff_out),   64'(0));
        chk({tag, "_idx"},    64'(coeff_idx),   64'(0));
        chk({tag, "_last"},   64'(coeff_last),  64'(0));
        chk({tag, "_busy"},   64'(busy),        64'(0));
        chk({tag, "_rdv"},    64'(rd_valid),    64'(0));
        chk({tag, "_rdd"},    64'(rd_data),     64'(0));
        chk({tag, "_rde"},    64'(rd_err),      64'(0));
    endtask

    logic [W-1:0]  e_d0, e_d1, e_d2;
    logic [SW-1:0] s_exp;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; coeff_ready = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        for (int k = 0; k < N; k++) cur[k] = '0;
        drive_bus();
        s_bus = '0; s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
        s_rd_en = 1'b0; s_rd_addr = '0;
        tick();
        chk_reset("rst0");
        chk("rst0_small_valid", 64'(s_valid), 64'(0));
        chk("rst0_small_busy",  64'(s_busy),  64'(0));
        rst = 1'b0;

        // 1: full sweep, ready held high, bus changes after the start edge
        for (int k = 0; k < N; k++) cur[k] = W'(k) * 32'h1111_1111 + 32'd1;
        drive_bus();
        take_snap();
        start = 1'b1; coeff_ready = 1'b1;
        tick();
        start = 1'b0;
        rand_bus();
        for (int i = 0; i < N; i++) begin
            chk_sweep("t1", i, snap[i]);
            tick();
        end
        chk("t1_end_valid", 64'(coeff_valid), 64'(0));
        chk("t1_end_busy",  64'(busy),        64'(0));
        chk("t1_end_last",  64'(coeff_last),  64'(0));
        chk("t1_end_idx",   64'(coeff_idx),   64'(N - 1));
        chk("t1_end_out",   64'(coeff_out),   64'(snap[N-1]));

        // 2: backpressure at idx 3 with the bus changing during the stall
        rand_bus(); take_snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_sweep("t2", i, snap[i]);
            tick();
        end
        coeff_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk_sweep("t2_stall", 3, snap[3]);
            rand_bus();
            tick();
        end
        coeff_ready = 1'b1;
        chk_sweep("t2_stall", 3, snap[3]);
        tick();
        for (int i = 4; i < N; i++) begin
            chk_sweep("t2", i, snap[i]);
            tick();
        end
        chk("t2_end_busy", 64'(busy), 64'(0));

        // 3: start mid-sweep ignored, start on final transfer chains, abort at 5
        rand_bus(); take_snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk_sweep("t3", i, snap[i]);
            if (i == 2) begin
                start = 1'b1; rand_bus();
            end else if (i == N - 1) begin
                start = 1'b1; rand_bus(); take_snap();
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        rand_bus();
        for (int i = 0; i <= 5; i++) begin
            chk_sweep("t3_chain", i, snap[i]);
            if (i == 5) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("t3_abort_valid", 64'(coeff_valid), 64'(0));
        chk("t3_abort_busy",  64'(busy),        64'(0));
        chk("t3_abort_idx",   64'(coeff_idx),   64'(5));
        chk("t3_abort_last",  64'(coeff_last),  64'(0));
        tick();
        chk("t3_idle_valid",  64'(coeff_valid), 64'(0));

        // 4: random-access reads 7, 10, 12 back to back with a changing bus
        rd_en = 1'b1; rd_addr = IW'(7); rand_bus(); e_d0 = cur[7];
        tick();
        rd_addr = IW'(10); rand_bus(); e_d1 = cur[10];
        chk("t4_r7_v", 64'(rd_valid), 64'(1));
        chk("t4_r7_d", 64'(rd_data),  64'(e_d0));
        chk("t4_r7_e", 64'(rd_err),   64'(0));
        tick();
        rd_addr = IW'(12); rand_bus(); e_d2 = cur[0];
        chk("t4_r10_v", 64'(rd_valid), 64'(1));
        chk("t4_r10_d", 64'(rd_data),  64'(e_d1));
        chk("t4_r10_e", 64'(rd_err),   64'(0));
        tick();
        rd_en = 1'b0; rand_bus();
        chk("t4_r12_v", 64'(rd_valid), 64'(1));
        chk("t4_r12_d", 64'(rd_data),  64'(e_d2));
        chk("t4_r12_e", 64'(rd_err),   64'(1));
        tick();
        chk("t4_hold_v", 64'(rd_valid), 64'(0));
        chk("t4_hold_d", 64'(rd_data),  64'(e_d2));
        chk("t4_hold_e", 64'(rd_err),   64'(1));

        // 5: read dropped in RUN, reset at idx 6, start+read together in IDLE
        rand_bus(); take_snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            chk_sweep("t5", i, snap[i]);
            if (i == 3) chk("t5_rd_drop", 64'(rd_valid), 64'(0));
            if (i == 2) begin
                rd_en = 1'b1; rd_addr = IW'(1);
            end else begin
                rd_en = 1'b0;
            end
            if (i == 6) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk_reset("t5_rst");
        tick();
        chk("t5_post_valid", 64'(coeff_valid), 64'(0));
        chk("t5_post_busy",  64'(busy),        64'(0));
        rand_bus(); take_snap();
        start = 1'b1; rd_en = 1'b1; rd_addr = IW'(3);
        tick();
        start = 1'b0; rd_en = 1'b0;
        chk("t5_both_rdv", 64'(rd_valid), 64'(0));
        chk_sweep("t5_both", 0, snap[0]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", 64'(busy), 64'(0));

        // 6: single-coefficient bank
        s_bus = SW'($urandom); s_exp = s_bus;
        s_start = 1'b1; s_ready = 1'b0;
        tick();
        s_start = 1'b0; s_bus = ~s_bus;
        chk("t6_valid", 64'(s_valid), 64'(1));
        chk("t6_last",  64'(s_last),  64'(1));
        chk("t6_idx",   64'(s_idx),   64'(0));
        chk("t6_out",   64'(s_out),   64'(s_exp));
        chk("t6_busy",  64'(s_busy),  64'(1));
        tick();
        chk("t6_hold_valid", 64'(s_valid), 64'(1));
        chk("t6_hold_out",   64'(s_out),   64'(s_exp));
        s_ready = 1'b1;
        tick();
        chk("t6_end_valid", 64'(s_valid), 64'(0));
        chk("t6_end_busy",  64'(s_busy),  64'(0));
        chk("t6_end_last",  64'(s_last),  64'(0));
        chk("t6_end_out",   64'(s_out),   64'(s_exp));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
